// File: rtl/class_pkg.sv
// Shared constants and FSM state type for the classifier key serializer.
package class_pkg;

  localparam int CLASS_BUS_WIDTH  = 128;
  localparam int CLASS_HASH_WIDTH = 13;
  localparam int CLASS_BEATS      = 3;

  // Serializer phases: idle, then one state per key beat on the hash bus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } ser_state_e;

endpackage

// File: rtl/class_sfifo.sv
// Synchronous first-word-fall-through FIFO. DEPTH must be a power of two.
// A pop and a push in the same cycle are both honoured, even when full.
module class_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; no reset needed since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/class_key_ser.sv
// Classifier hash initiator: serializes a padded key onto the hash block's
// key bus in three beats and pairs returned hashes with their request tags.
module class_key_ser
  import class_pkg::*;
#(
  parameter int BUS_WIDTH  = CLASS_BUS_WIDTH,
  parameter int HASH_WIDTH = CLASS_HASH_WIDTH,
  parameter int KEY_WIDTH  = 320,
  parameter int TAG_WIDTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [KEY_WIDTH-1:0]  req_key,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [BUS_WIDTH-1:0]  key,
  output logic                  key_start,
  input  logic                  hash_vld,
  input  logic [HASH_WIDTH-1:0] h1k,
  input  logic [HASH_WIDTH-1:0] h2k,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [HASH_WIDTH-1:0] rsp_h1k,
  output logic [HASH_WIDTH-1:0] rsp_h2k,
  output logic                  err_unexp
);

  localparam int KQ_WIDTH = CLASS_BEATS * BUS_WIDTH;
  localparam int CW       = $clog2(RSP_DEPTH + 1);
  localparam int RSP_W    = TAG_WIDTH + 2 * HASH_WIDTH;

  ser_state_e           state;
  logic [KQ_WIDTH-1:0]  key_q;
  logic [KQ_WIDTH-1:0]  key_pad;
  logic [CW-1:0]        credits;
  logic                 accept;
  logic                 rsp_pop;
  logic                 rsp_push;
  logic                 rsp_empty;
  logic [RSP_W-1:0]     rsp_rdata;
  logic [TAG_WIDTH-1:0] tag_head;
  logic                 tag_empty;
  logic                 tag_full_unused;
  logic                 rsp_full_unused;

  assign key_pad  = KQ_WIDTH'(req_key);
  assign req_rdy  = !rst && (state == ST_IDLE || state == ST_B2) &&
                    (credits < CW'(RSP_DEPTH));
  assign accept   = req_vld && req_rdy;
  assign rsp_vld  = !rsp_empty;
  assign rsp_pop  = rsp_vld && rsp_rdy;
  assign rsp_push = hash_vld && !tag_empty;
  assign {rsp_tag, rsp_h1k, rsp_h2k} = rsp_rdata;

  // Beat sequencer: a new key can start in the last beat of the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      key_q     <= '0;
      key       <= '0;
      key_start <= 1'b0;
    end else begin
      case (state)
        ST_B0: begin
          state     <= ST_B1;
          key       <= key_q[BUS_WIDTH +: BUS_WIDTH];
          key_start <= 1'b0;
        end
        ST_B1: begin
          state     <= ST_B2;
          key       <= key_q[2*BUS_WIDTH +: BUS_WIDTH];
          key_start <= 1'b0;
        end
        default: begin
          if (accept) begin
            state     <= ST_B0;
            key_q     <= key_pad;
            key       <= key_pad[BUS_WIDTH-1:0];
            key_start <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            key       <= '0;
            key_start <= 1'b0;
          end
        end
      endcase
    end
  end

  // Credits bound outstanding requests so the response FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({accept, rsp_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for a hash result that has no request waiting for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp <= 1'b0;
    end else if (hash_vld && tag_empty) begin
      err_unexp <= 1'b1;
    end
  end

  class_sfifo #(
    .WIDTH (TAG_WIDTH),
    .DEPTH (2)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (req_tag),
    .pop   (hash_vld),
    .rdata (tag_head),
    .full  (tag_full_unused),
    .empty (tag_empty)
  );

  class_sfifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .wdata ({tag_head, h1k, h2k}),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .full  (rsp_full_unused),
    .empty (rsp_empty)
  );

endmodule

// File: tb/tb_class_key_ser.sv
// Testbench for class_key_ser: directed scenarios plus randomized traffic,
// compared every cycle against a timing/queue model of the interface.
module tb_class_key_ser;

  localparam int BW = 128;
  localparam int HW = 13;
  localparam int KW = 320;
  localparam int TW = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_vld;
  logic          req_rdy;
  logic [KW-1:0] req_key;
  logic [TW-1:0] req_tag;
  logic [BW-1:0] key;
  logic          key_start;
  logic          hash_vld;
  logic [HW-1:0] h1k;
  logic [HW-1:0] h2k;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [TW-1:0] rsp_tag;
  logic [HW-1:0] rsp_h1k;
  logic [HW-1:0] rsp_h2k;
  logic          err_unexp;

  class_key_ser #(
    .BUS_WIDTH  (BW),
    .HASH_WIDTH (HW),
    .KEY_WIDTH  (KW),
    .TAG_WIDTH  (TW),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_key   (req_key),
    .req_tag   (req_tag),
    .key       (key),
    .key_start (key_start),
    .hash_vld  (hash_vld),
    .h1k       (h1k),
    .h2k       (h2k),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_tag   (rsp_tag),
    .rsp_h1k   (rsp_h1k),
    .rsp_h2k   (rsp_h2k),
    .err_unexp (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [HW-1:0] h1;
    logic [HW-1:0] h2;
  } rsp_t;

  // Reference model: time of the last accepted key, queued tags/responses.
  rsp_t          rspq[$];
  logic [TW-1:0] tagq[$];
  int            sched[$];
  int            cyc         = 0;
  int            last_acc    = -100;
  int            outstanding = 0;
  bit            m_err       = 1'b0;
  bit            model_on    = 1'b0;
  logic [3*BW-1:0] last_key  = '0;

  int            checks = 0;
  int            errors = 0;
  logic [HW-1:0] hv1;
  logic [HW-1:0] hv2;

  function automatic bit exp_rdy();
    return !rst && (cyc - last_acc >= 3) && (outstanding < RD);
  endfunction

  function automatic logic [BW-1:0] exp_key();
    int d;
    d = cyc - last_acc;
    if (d >= 1 && d <= 3) return last_key[(d-1)*BW +: BW];
    return '0;
  endfunction

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < KW/32; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  task automatic checkOutput(input string name, input logic [BW-1:0] act,
                             input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; the hash block answers 4 cycles after accept.
  task automatic applyStimulus(input bit r, input bit v, input logic [KW-1:0] k,
                               input logic [TW-1:0] t, input bit rr);
    @(posedge clk);
    #2;
    rst     = r;
    req_vld = v;
    req_key = k;
    req_tag = t;
    rsp_rdy = rr;
    while (sched.size() > 0 && sched[0] < cyc) void'(sched.pop_front());
    if (sched.size() > 0 && sched[0] == cyc) begin
      void'(sched.pop_front());
      hash_vld = 1'b1;
      h1k      = hv1;
      h2k      = hv2;
    end else begin
      hash_vld = 1'b0;
      h1k      = HW'($urandom);
      h2k      = HW'($urandom);
    end
    #2;
  endtask

  // Model update at each clock edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    bit   acc;
    bit   pop;
    rsp_t e;
    if (rst) begin
      model_on    = 1'b1;
      last_acc    = -100;
      outstanding = 0;
      m_err       = 1'b0;
      tagq.delete();
      rspq.delete();
    end else if (model_on) begin
      acc = req_vld && exp_rdy();
      pop = (rspq.size() > 0) && rsp_rdy;
      if (pop) begin
        void'(rspq.pop_front());
        outstanding--;
      end
      if (hash_vld) begin
        if (tagq.size() == 0) begin
          m_err = 1'b1;
        end else begin
          e.tag = tagq.pop_front();
          e.h1  = h1k;
          e.h2  = h2k;
          rspq.push_back(e);
        end
      end
      if (acc) begin
        tagq.push_back(req_tag);
        last_acc = cyc;
        last_key = (3*BW)'(req_key);
        outstanding++;
        sched.push_back(cyc + 4);
      end
    end
    cyc++;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("req_rdy", BW'(req_rdy), BW'(exp_rdy()));
      checkOutput("key", key, exp_key());
      checkOutput("key_start", BW'(key_start), BW'(cyc - last_acc == 1));
      checkOutput("err_unexp", BW'(err_unexp), BW'(m_err));
      checkOutput("rsp_vld", BW'(rsp_vld), BW'(rspq.size() != 0));
      if (rspq.size() != 0) begin
        checkOutput("rsp_tag", BW'(rsp_tag), BW'(rspq[0].tag));
        checkOutput("rsp_h1k", BW'(rsp_h1k), BW'(rspq[0].h1));
        checkOutput("rsp_h2k", BW'(rsp_h2k), BW'(rspq[0].h2));
      end
    end
  end

  initial begin
    logic [KW-1:0] k1;
    logic [BW-1:0] pad_beat;
    int            n;

    rst = 1'b1; req_vld = 1'b0; req_key = '0; req_tag = '0;
    rsp_rdy = 1'b1; hash_vld = 1'b0; h1k = '0; h2k = '0;
    hv1 = '0; hv2 = '0;

    // Reset state
    applyStimulus(1, 0, '0, 0, 1);
    checkOutput("reset req_rdy", BW'(req_rdy), 0);
    applyStimulus(1, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("reset key", key, 0);
    checkOutput("reset key_start", BW'(key_start), 0);
    checkOutput("reset rsp_vld", BW'(rsp_vld), 0);
    checkOutput("reset err_unexp", BW'(err_unexp), 0);
    checkOutput("idle req_rdy", BW'(req_rdy), 1);

    // Single request: bits 1 and 256 set, tag 5
    k1 = '0; k1[1] = 1'b1; k1[256] = 1'b1;
    hv1 = 13'h0ABC; hv2 = 13'h1234;
    applyStimulus(0, 1, k1, 5, 1);
    checkOutput("t1 accept", BW'(req_rdy), 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t1 beat0", key, 128'h2);
    checkOutput("t1 start0", BW'(key_start), 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t1 beat1", key, 128'h0);
    checkOutput("t1 start1", BW'(key_start), 0);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t1 beat2", key, 128'h1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t1 rsp early", BW'(rsp_vld), 0);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("t1 rsp_vld", BW'(rsp_vld), 1);
    checkOutput("t1 rsp_tag", BW'(rsp_tag), 5);
    checkOutput("t1 rsp_h1k", BW'(rsp_h1k), BW'(13'h0ABC));
    checkOutput("t1 rsp_h2k", BW'(rsp_h2k), BW'(13'h1234));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 0, 1);

    // Back-to-back tags 1,2,3
    for (int i = 0; i <= 12; i++) begin
      hv1 = HW'($urandom); hv2 = HW'($urandom);
      applyStimulus(0, i < 7, rand_key(), TW'(1 + i/3), 1);
      if (i >= 1 && i <= 9)
        checkOutput("b2b key_start", BW'(key_start), BW'(i == 1 || i == 4 || i == 7));
      if (i >= 5 && i <= 11)
        checkOutput("b2b rsp_vld", BW'(rsp_vld), BW'(i % 3 == 2));
      if (i == 5)  checkOutput("b2b tag1", BW'(rsp_tag), 1);
      if (i == 8)  checkOutput("b2b tag2", BW'(rsp_tag), 2);
      if (i == 11) checkOutput("b2b tag3", BW'(rsp_tag), 3);
    end

    // Credit exhaustion with rsp_rdy low
    n = 0;
    for (int i = 0; i < 16; i++) begin
      hv1 = HW'($urandom); hv2 = HW'($urandom);
      applyStimulus(0, 1, rand_key(), TW'($urandom), 0);
      if (req_vld && req_rdy) n++;
    end
    checkOutput("credit accepts", BW'(n), 4);
    applyStimulus(0, 1, rand_key(), TW'($urandom), 1);
    checkOutput("full pop req_rdy", BW'(req_rdy), 0);
    checkOutput("full pop rsp_vld", BW'(rsp_vld), 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      hv1 = HW'($urandom); hv2 = HW'($urandom);
      applyStimulus(0, 1, rand_key(), TW'($urandom), 0);
      if (req_vld && req_rdy) n++;
    end
    checkOutput("one more accept", BW'(n), 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, '0, 0, 1);

    // Reset during the middle beat abandons the key
    applyStimulus(0, 1, rand_key(), 7, 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("rb start", BW'(key_start), 1);
    applyStimulus(1, 0, '0, 0, 1);
    checkOutput("rb req_rdy", BW'(req_rdy), 0);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("rb key", key, 0);
    checkOutput("rb key_start", BW'(key_start), 0);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("rb err_unexp", BW'(err_unexp), 1);
    checkOutput("rb rsp_vld", BW'(rsp_vld), 0);

    // All-ones key padding
    applyStimulus(1, 0, '0, 0, 1);
    applyStimulus(0, 0, '0, 0, 1);
    applyStimulus(0, 1, '1, 9, 1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("pad beat0", key, '1);
    applyStimulus(0, 0, '0, 0, 1);
    checkOutput("pad beat1", key, '1);
    applyStimulus(0, 0, '0, 0, 1);
    pad_beat = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    checkOutput("pad beat2", key, pad_beat);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, '0, 0, 1);

    // Randomized traffic with occasional resets and back-pressure
    for (int i = 0; i < 3000; i++) begin
      hv1 = HW'($urandom); hv2 = HW'($urandom);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6,
                    rand_key(), TW'($urandom), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, '0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
